// File: rtl/imem_axi_rd_slave.sv
// AXI4 read-only responder over a local synchronous-read word memory with a loader write port.
// One burst outstanding; INCR/FIXED beats stream back-to-back while RREADY stays high.
module imem_axi_rd_slave #(
  parameter int unsigned                        C_S_AXI_THREAD_ID_WIDTH = 1,
  parameter int unsigned                        C_S_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned                        C_S_AXI_DATA_WIDTH      = 32,
  parameter int unsigned                        C_S_AXI_RUSER_WIDTH     = 4,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]      C_BASE_ADDR             = 32'h2000_0000,
  parameter int unsigned                        C_MEM_WORDS_LOG2        = 12
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic                               LD_WE,
  input  logic [C_MEM_WORDS_LOG2-1:0]        LD_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      LD_DATA,
  input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [7:0]                         S_AXI_ARLEN,
  input  logic [2:0]                         S_AXI_ARSIZE,
  input  logic [1:0]                         S_AXI_ARBURST,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0]     S_AXI_RUSER,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IW = C_MEM_WORDS_LOG2;

  typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

  state_e                             state_q, state_d;
  logic                               arready_q;
  logic                               fetch_phase_q;
  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]                      addr_q;
  logic [7:0]                         len_q, cnt_q;
  logic                               fixed_q, err_q;

  logic          ar_hs, beat_hs, last, rvalid, in_range, rd_en;
  logic [AW-1:0] next_addr, rd_addr, off_cur, off_rd;
  logic [IW-1:0] rd_idx;
  logic [1:0]    resp;
  logic [DW-1:0] mem [1 << IW];
  logic [DW-1:0] rd_data_q;
  logic          unused_bits;

  assign rvalid    = (state_q == StResp);
  assign ar_hs     = arready_q && S_AXI_ARVALID;
  assign last      = (cnt_q == len_q);
  assign beat_hs   = rvalid && S_AXI_RREADY;
  assign next_addr = fixed_q ? addr_q : addr_q + AW'(4);

  // On a non-last handshake the next beat is read now so it is on RDATA next cycle.
  assign rd_addr = rvalid ? next_addr : addr_q;
  assign rd_en   = (state_q == StFetch && fetch_phase_q) || (beat_hs && !last);
  assign off_rd  = rd_addr - C_BASE_ADDR;
  assign rd_idx  = off_rd[IW+1:2];

  assign off_cur  = addr_q - C_BASE_ADDR;
  assign in_range = (off_cur >> (IW + 2)) == '0;
  assign resp     = err_q ? 2'b10 : (in_range ? 2'b00 : 2'b11);

  assign unused_bits = ^{S_AXI_ARADDR[1:0], off_rd[1:0], off_rd[AW-1:IW+2]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ar_hs) state_d = StFetch;
      // Two fetch cycles give the fixed two-edge AR-to-R latency.
      StFetch: if (fetch_phase_q) state_d = StResp;
      StResp:  if (beat_hs && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= StIdle;
      arready_q     <= 1'b0;
      fetch_phase_q <= 1'b0;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      fixed_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      arready_q     <= (state_d == StIdle);
      fetch_phase_q <= (state_q == StFetch) && !fetch_phase_q;
      if (ar_hs) begin
        id_q    <= S_AXI_ARID;
        addr_q  <= {S_AXI_ARADDR[AW-1:2], 2'b00};
        len_q   <= S_AXI_ARLEN;
        cnt_q   <= '0;
        fixed_q <= (S_AXI_ARBURST == 2'b00);
        err_q   <= (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
      end else if (beat_hs && !last) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

  // Not reset: contents survive RSTN. Same-index write and read return the old word.
  always_ff @(posedge CLK) begin
    if (LD_WE) mem[LD_ADDR] <= LD_DATA;
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RID     = rvalid ? id_q : '0;
  assign S_AXI_RRESP   = rvalid ? resp : 2'b00;
  assign S_AXI_RLAST   = rvalid && last;
  assign S_AXI_RDATA   = (rvalid && resp == 2'b00) ? rd_data_q : '0;
  assign S_AXI_RUSER   = '0;

endmodule

// File: tb/tb_imem_axi_rd_slave.sv
// Directed bench for imem_axi_rd_slave: burst vector table plus read-first and mid-burst reset.
module tb_imem_axi_rd_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [0:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  ruser;
  logic        rvalid;
  logic        rready = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_axi_rd_slave #(
    .C_S_AXI_THREAD_ID_WIDTH(1),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_RUSER_WIDTH(4),
    .C_BASE_ADDR(32'h2000_0000),
    .C_MEM_WORDS_LOG2(4)
  ) dut (
    .CLK(clk), .RSTN(rstn),
    .LD_WE(ld_we), .LD_ADDR(ld_addr), .LD_DATA(ld_data),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct {
    logic [0:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       pat;   // RREADY per cycle, bit (cycle % 4)
    logic [3:0][31:0] data;  // expected RDATA per beat
    logic [3:0][1:0]  resp;  // expected RRESP per beat
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] pat, input logic [127:0] data,
                              input logic [7:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.pat = pat; v.data = data; v.resp = resp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 4'(idx); ld_data = val;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_burst(input int vi, input vec_t v);
    int n;
    int cyc;
    @(negedge clk);
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1; rready = 1'b0;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d arready", vi), 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk($sformatf("v%0d arready_drop", vi), 32'(arready), 32'd0);
    chk($sformatf("v%0d lat0", vi), 32'(rvalid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d lat1", vi), 32'(rvalid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d lat2", vi), 32'(rvalid), 32'd1);
    n = 0;
    cyc = 0;
    while (n <= int'(v.len) && cyc < 64) begin
      rready = v.pat[cyc % 4];
      if (rvalid) begin
        chk($sformatf("v%0d b%0d data", vi, n), rdata, v.data[n]);
        chk($sformatf("v%0d b%0d resp", vi, n), 32'(rresp), 32'(v.resp[n]));
        chk($sformatf("v%0d b%0d last", vi, n), 32'(rlast), 32'(n == int'(v.len)));
        chk($sformatf("v%0d b%0d id", vi, n), 32'(rid), 32'(v.id));
        if (rready) n++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk($sformatf("v%0d beats", vi), 32'(n), 32'(int'(v.len) + 1));
    chk($sformatf("v%0d rvalid_end", vi), 32'(rvalid), 32'd0);
    chk($sformatf("v%0d arready_end", vi), 32'(arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int stray;

    vecs[0] = mk(1'b1, 32'h2000_0000, 8'd3, 3'd2, 2'b01, 4'b1111,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}, 8'h00);
    vecs[1] = mk(1'b1, 32'h2000_0000, 8'd3, 3'd2, 2'b01, 4'b1001,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}, 8'h00);
    vecs[2] = mk(1'b0, 32'h2000_0008, 8'd2, 3'd2, 2'b00, 4'b1111,
                 {32'h0, 32'h1000_0002, 32'h1000_0002, 32'h1000_0002}, 8'h00);
    vecs[3] = mk(1'b1, 32'h2000_0038, 8'd3, 3'd2, 2'b01, 4'b1111,
                 {32'h0, 32'h0, 32'h1000_000F, 32'h1000_000E}, 8'b11_11_00_00);
    vecs[4] = mk(1'b0, 32'h1FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'b1111,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 8'b00_00_00_11);
    vecs[5] = mk(1'b1, 32'h2000_0000, 8'd1, 3'd1, 2'b01, 4'b0110,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 8'b00_00_10_10);
    vecs[6] = mk(1'b0, 32'h2000_0004, 8'd1, 3'd2, 2'b10, 4'b1111,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 8'b00_00_10_10);
    vecs[7] = mk(1'b1, 32'h2000_0006, 8'd1, 3'd2, 2'b01, 4'b1111,
                 {32'h0, 32'h0, 32'h1000_0002, 32'h1000_0001}, 8'h00);
    vecs[8] = mk(1'b0, 32'h2000_003C, 8'd1, 3'd2, 2'b00, 4'b1011,
                 {32'h0, 32'h0, 32'h1000_000F, 32'h1000_000F}, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst arready", 32'(arready), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rlast", 32'(rlast), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst rresp", 32'(rresp), 32'd0);
    chk("rst rid", 32'(rid), 32'd0);
    chk("rst ruser", 32'(ruser), 32'd0);
    rstn = 1'b1;
    #1;
    chk("release arready_pre", 32'(arready), 32'd0);
    @(negedge clk);
    chk("release arready", 32'(arready), 32'd1);

    for (int i = 0; i < 16; i++) load(i, 32'h1000_0000 + 32'(i));

    for (int i = 0; i < 9; i++) run_burst(i, vecs[i]);

    // Read-first: loader write to word 2 lands on the same edge as the beat-0 read
    @(negedge clk);
    chk("rf arready", 32'(arready), 32'd1);
    arid = 1'b0; araddr = 32'h2000_0008; arlen = 8'd1; arsize = 3'd2; arburst = 2'b00;
    arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 4'd2; ld_data = 32'hCAFE_0002;
    @(negedge clk);
    ld_we = 1'b0;
    chk("rf b0 rvalid", 32'(rvalid), 32'd1);
    chk("rf b0 old", rdata, 32'h1000_0002);
    rready = 1'b1;
    @(negedge clk);
    chk("rf b1 rvalid", 32'(rvalid), 32'd1);
    chk("rf b1 new", rdata, 32'hCAFE_0002);
    chk("rf b1 last", 32'(rlast), 32'd1);
    @(negedge clk);
    rready = 1'b0;
    chk("rf done", 32'(rvalid), 32'd0);
    load(2, 32'h1000_0002);

    // Reset during beat 2 of an 8-beat burst from word 4
    @(negedge clk);
    arid = 1'b1; araddr = 32'h2000_0010; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    cyc = 0;
    while (!(rvalid && n == 2) && cyc < 20) begin
      if (rvalid) n++;
      @(negedge clk);
      cyc++;
    end
    chk("mr beat2 rvalid", 32'(rvalid), 32'd1);
    chk("mr beat2 data", rdata, 32'h1000_0006);
    rstn = 1'b0;
    #1;
    chk("mr rvalid", 32'(rvalid), 32'd0);
    chk("mr arready", 32'(arready), 32'd0);
    chk("mr rdata", rdata, 32'd0);
    chk("mr rlast", 32'(rlast), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mr arready_after", 32'(arready), 32'd1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (rvalid) stray++;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("mr stray_beats", 32'(stray), 32'd0);
    run_burst(100, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
